// File: rtl/console_writer.sv
// Terminal-style byte-stream writer: turns host bytes into framebuffer writes
// (glyphs, blanks, palette entries) while tracking a cursor over the text grid.
module console_writer #(
  parameter int         HTILES     = 80,
  parameter int         VTILES     = 60,
  parameter int         ADDR_W     = 13,
  parameter logic [7:0] BLANK_CHR  = 8'h20,
  parameter bit         CLR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [6:0]        o_cur_x,
  output logic [5:0]        o_cur_y,
  output logic              o_busy
);

  localparam int FB_SIZE = HTILES * VTILES;
  localparam logic [ADDR_W-1:0] PAL_BASE = ADDR_W'(FB_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_ESC_IDX, S_ESC_VAL, S_CLR_LINE, S_CLR_ALL} state_t;

  state_t              state_q, state_d;
  logic [6:0]          x_q, x_d;
  logic [5:0]          y_q, y_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          idx_q, idx_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;

  logic                accept;
  logic [5:0]          y_next;
  logic [ADDR_W-1:0]   cur_addr, next_row_base;

  assign o_ready   = (state_q == S_IDLE) || (state_q == S_ESC_IDX) || (state_q == S_ESC_VAL);
  assign o_busy    = (state_q == S_CLR_LINE) || (state_q == S_CLR_ALL);
  assign accept    = i_valid && o_ready;
  assign y_next    = (y_q == 6'(VTILES - 1)) ? 6'd0 : y_q + 6'd1;
  assign cur_addr  = ADDR_W'(y_q) * ADDR_W'(HTILES) + ADDR_W'(x_q);
  assign next_row_base = ADDR_W'(y_next) * ADDR_W'(HTILES);

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_cur_x   = x_q;
  assign o_cur_y   = y_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        unique case (i_data)
          8'h0D: x_d = '0;
          8'h0A: begin
            x_d     = '0;
            y_d     = y_next;
            base_d  = next_row_base;
            cnt_d   = '0;
            state_d = S_CLR_LINE;
          end
          8'h08: if (x_q != '0) begin
            x_d       = x_q - 7'd1;
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr - ADDR_W'(1);
            wr_data_d = BLANK_CHR;
          end
          8'h0C: begin
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            state_d = S_CLR_ALL;
          end
          8'h1B: state_d = S_ESC_IDX;
          default: begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = i_data;
            if (x_q == 7'(HTILES - 1)) begin
              // Wrapping off the right edge behaves like LF: new row is blanked.
              x_d     = '0;
              y_d     = y_next;
              base_d  = next_row_base;
              cnt_d   = '0;
              state_d = S_CLR_LINE;
            end else begin
              x_d = x_q + 7'd1;
            end
          end
        endcase
      end
      S_ESC_IDX: if (accept) begin
        idx_d   = i_data;
        state_d = S_ESC_VAL;
      end
      S_ESC_VAL: if (accept) begin
        if (idx_q <= 8'd17) begin
          wr_en_d   = 1'b1;
          wr_addr_d = PAL_BASE + ADDR_W'(idx_q);
          wr_data_d = i_data;
        end
        state_d = S_IDLE;
      end
      S_CLR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_q + cnt_q;
        wr_data_d = BLANK_CHR;
        if (cnt_q == ADDR_W'(HTILES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_CLR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = BLANK_CHR;
        if (cnt_q == ADDR_W'(FB_SIZE - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLR_ON_RST ? S_CLR_ALL : S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
